// File: rtl/config_pkg.sv
// Shared constants and types for the serial configuration loader.
package config_pkg;

  localparam int         DEFAULT_CFG_W = 5;
  localparam logic [7:0] SYNC_WORD     = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } cfg_state_t;

  typedef logic [DEFAULT_CFG_W-1:0] cfg_word_t;

endpackage

// File: rtl/cfg_deserializer.sv
// LSB-first word deserializer; pulses word_valid on the beat that completes a word.
// With CFG_LOADER_PARITY_EN each word carries a trailing even-parity bit.
module cfg_deserializer
  import config_pkg::*;
#(
  parameter int CFG_W = DEFAULT_CFG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             accept,
  input  logic             bit_in,
  output logic             word_valid,
  output logic             parity_ok,
  output logic [CFG_W-1:0] word
);

`ifdef CFG_LOADER_PARITY_EN
  localparam int BEATS = CFG_W + 1;
`else
  localparam int BEATS = CFG_W;
`endif
  localparam int CW = $clog2(BEATS + 1);

  logic [CW-1:0]    cnt;
  logic [CFG_W-1:0] shreg;
  logic             last;

  assign last       = (cnt == CW'(BEATS - 1));
  assign word_valid = accept && last;

  // word is the register contents with the current beat merged in
  always_comb begin
    word = shreg;
    if (cnt < CW'(CFG_W)) word[cnt] = bit_in;
  end

`ifdef CFG_LOADER_PARITY_EN
  assign parity_ok = ~(^shreg ^ bit_in);
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (clear) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (accept) begin
      if (last) begin
        cnt   <= '0;
        shreg <= '0;
      end else begin
        cnt   <= cnt + 1'b1;
        shreg <= word;
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader: sync-word hunt, then one word per logic block with a one-hot strobe.
// Optional per-word even parity is enabled by defining CFG_LOADER_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for start, not accepting bits
// SYNC  | shifting bits until SYNC_WORD is seen
// LOAD  | deserializing and writing block words
// DONE  | all blocks written, done held until start
// ERROR | parity failure, error held until start
module config_loader
  import config_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int CFG_W      = DEFAULT_CFG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [CFG_W-1:0]      cfg_out,
  output logic [NUM_BLOCKS-1:0] cfg_we,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;
  localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  logic [2:0]       state;
  logic [7:0]       sync_q;
  logic [7:0]       sync_shift;
  logic [IW-1:0]    idx;
  logic             accept;
  logic             word_valid;
  logic             parity_ok;
  logic [CFG_W-1:0] word;

  assign busy       = (state == S_SYNC) || (state == S_LOAD);
  assign bit_ready  = busy;
  assign accept     = bit_valid && bit_ready;
  assign done       = (state == S_DONE);
  assign sync_shift = {sync_q[6:0], bit_in};

`ifdef CFG_LOADER_PARITY_EN
  assign error = (state == S_ERROR);
`else
  assign error = 1'b0;
`endif

  cfg_deserializer #(.CFG_W(CFG_W)) u_deser (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != S_LOAD),
    .accept     (accept && (state == S_LOAD)),
    .bit_in     (bit_in),
    .word_valid (word_valid),
    .parity_ok  (parity_ok),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      sync_q  <= '0;
      idx     <= '0;
      cfg_out <= '0;
      cfg_we  <= '0;
    end else begin
      cfg_we <= '0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state  <= S_SYNC;
            sync_q <= '0;
          end
        end
        S_SYNC: begin
          if (accept) begin
            if (sync_shift == SYNC_WORD) begin
              state  <= S_LOAD;
              sync_q <= '0;
              idx    <= '0;
            end else begin
              sync_q <= sync_shift;
            end
          end
        end
        S_LOAD: begin
          if (word_valid) begin
            if (parity_ok) begin
              cfg_out <= word;
              cfg_we  <= NUM_BLOCKS'(1) << idx;
              idx     <= idx + 1'b1;
              if (idx == IW'(NUM_BLOCKS - 1)) state <= S_DONE;
            end else begin
              state <= S_ERROR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed, table-driven bench for config_loader; strobes are captured on the falling edge.
module tb_config_loader;

  localparam int NB = 4;
  localparam int W  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic [W-1:0]  cfg_out;
  logic [NB-1:0] cfg_we;
  logic          busy, done, error;

  always #5 clk = ~clk;

  config_loader #(.NUM_BLOCKS(NB), .CFG_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .cfg_out(cfg_out), .cfg_we(cfg_we), .busy(busy),
    .done(done), .error(error)
  );

  typedef struct {
    logic [W-1:0]  word;
    logic [NB-1:0] we;
    logic          done;
  } vec_t;

  typedef struct packed {
    logic [NB-1:0] we;
    logic [W-1:0]  out;
    logic          done;
  } rec_t;

  vec_t vecs[NB];
  rec_t got[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk)
    if (reset && cfg_we != '0) got.push_back({cfg_we, cfg_out, done});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit stall, input bit pulse);
    if (stall) begin
      repeat ($urandom_range(0, 1) * $urandom_range(1, 2)) begin
        @(negedge clk);
        bit_valid = 1'b0;
        start     = 1'b0;
      end
    end
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
    start     = pulse;
  endtask

  // start pulse, optional garbage (MSB first), sync word, then table words LSB first
  task automatic load_stream(input int garbage_n, input logic [7:0] garbage, input bit stall,
                             input int start_at, input int stop_after);
    logic q[$];
    logic [7:0] sw;
    sw = 8'hA5;
    @(negedge clk);
    start     = 1'b1;
    bit_valid = 1'b0;
    for (int i = garbage_n - 1; i >= 0; i--) q.push_back(garbage[i]);
    for (int i = 7; i >= 0; i--) q.push_back(sw[i]);
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < W; k++) q.push_back(vecs[b].word[k]);
`ifdef CFG_LOADER_PARITY_EN
      q.push_back(^vecs[b].word);
`endif
    end
    for (int i = 0; i < q.size(); i++) begin
      if (stop_after >= 0 && i >= stop_after) break;
      send_bit(q[i], stall, i == start_at);
    end
    @(negedge clk);
    bit_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic check_records(input string tag);
    int n;
    repeat (3) @(negedge clk);
    check({tag, "_count"}, got.size(), NB);
    n = (got.size() < NB) ? got.size() : NB;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_we%0d", tag, i),   got[i].we,   vecs[i].we);
      check($sformatf("%s_out%0d", tag, i),  got[i].out,  vecs[i].word);
      check($sformatf("%s_done%0d", tag, i), got[i].done, vecs[i].done);
    end
    check({tag, "_done_hold"}, done, 1'b1);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_ready_end"}, bit_ready, 1'b0);
    got.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bit_ready"}, bit_ready, 1'b0);
    check({tag, "_cfg_out"}, cfg_out, '0);
    check({tag, "_cfg_we"}, cfg_we, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    int partial;
    vecs[0] = '{word: 5'h1F, we: 4'b0001, done: 1'b0};
    vecs[1] = '{word: 5'h00, we: 4'b0010, done: 1'b0};
    vecs[2] = '{word: 5'h15, we: 4'b0100, done: 1'b0};
    vecs[3] = '{word: 5'h0A, we: 4'b1000, done: 1'b1};

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    load_stream(0, 8'h00, 1'b0, -1, -1);
    check_records("full_rate");

    load_stream(4, 8'h06, 1'b0, -1, -1);
    check_records("garbage");

    load_stream(0, 8'h00, 1'b1, -1, -1);
    check_records("stalls");

    load_stream(0, 8'h00, 1'b0, 20, -1);
    check_records("start_busy");

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_done", done, 1'b0);
    check("restart_ready", bit_ready, 1'b1);
    check("restart_busy", busy, 1'b1);

`ifdef CFG_LOADER_PARITY_EN
    partial = 8 + 2 * (W + 1) + 2;
`else
    partial = 8 + 2 * W + 2;
`endif
    load_stream(0, 8'h00, 1'b0, -1, partial);
    check("midload_strobes", got.size(), 2);
    check("midload_busy", busy, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    got.delete();
    @(negedge clk);
    reset = 1'b1;
    load_stream(0, 8'h00, 1'b0, -1, -1);
    check_records("after_reset");

`ifdef CFG_LOADER_PARITY_EN
    begin
      logic pq[$];
      logic [7:0] sw;
      logic [W-1:0] bad;
      sw  = 8'hA5;
      bad = 5'h07;
      @(negedge clk);
      start = 1'b1;
      for (int i = 7; i >= 0; i--) pq.push_back(sw[i]);
      for (int k = 0; k < W; k++) pq.push_back(bad[k]);
      pq.push_back(1'b0);
      for (int i = 0; i < pq.size(); i++) send_bit(pq[i], 1'b0, 1'b0);
      @(negedge clk);
      bit_valid = 1'b0;
      check("parity_no_strobe", got.size(), 0);
      check("parity_error", error, 1'b1);
      check("parity_ready", bit_ready, 1'b0);
      check("parity_busy", busy, 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("parity_error_clear", error, 1'b0);
      load_stream(0, 8'h00, 1'b0, -1, -1);
      check_records("parity_recover");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
